mm_write_sink: RTL and testbench

Memory-mapped write slave on the `bus_MM` bus. It sits directly downstream of the bus master and consumes every write the master issues inside a configurable address window. Each accepted write is stored as an {address, data} pair in an internal FIFO and presented on a valid/ready stream port for the next stage. The bus has no wait-request, so the block can never stall the master: writes that arrive while the FIFO is full are dropped and counted.

---
 rtl/mm_write_sink.sv | 99 +++++++++
 tb/tb_mm_write_sink.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_write_sink.sv
// Memory-mapped write slave: captures in-window bus writes into a FIFO of
// {address, data} pairs and presents them on a first-word-fall-through stream.
module mm_write_sink #(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] ADDR_LO = 8'd0,
    parameter logic [7:0] ADDR_HI = 8'd98
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [7:0]               address,
    input  logic                     write,
    input  logic [7:0]               writedata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_addr,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              accept_cnt,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          hit;
    logic          pop;
    logic          push;
    logic          drop;

    // Signed compare keeps a zero lower bound from becoming a constant-true test.
    assign hit  = write && (int'(address) >= int'(ADDR_LO))
                        && (int'(address) <= int'(ADDR_HI));
    assign pop  = out_valid && out_ready;
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // NOTE: storage carries no reset; level/empty gate the outputs so stale
    // contents are never visible, and a reset-free array maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (push && !reset) begin
            mem[wr_ptr] <= '{addr: address, data: writedata};
        end
    end

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            accept_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                accept_cnt <= accept_cnt + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // NOTE: every output of this block is assigned up front, so no latch is inferred.
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = !empty;
        out_addr  = '0;
        out_data  = '0;
        if (out_valid) begin
            out_addr = head.addr;
            out_data = head.data;
        end
    end

endmodule

// File: tb/tb_mm_write_sink.sv
// Self-checking bench for mm_write_sink: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the write sink.
module tb_mm_write_sink;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int LO    = 0;
    localparam int HI    = 98;

    logic          CLK;
    logic          reset;
    logic [7:0]    address;
    logic          write;
    logic [7:0]    writedata;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_addr;
    logic [7:0]    out_data;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic [15:0]   accept_cnt;
    logic [7:0]    drop_cnt;

    mm_write_sink #(.DEPTH(DEPTH), .ADDR_LO(8'(LO)), .ADDR_HI(8'(HI))) dut (
        .CLK        (CLK),
        .reset      (reset),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .accept_cnt (accept_cnt),
        .drop_cnt   (drop_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic          valid;
        logic [7:0]    addr;
        logic [7:0]    data;
        logic [LW-1:0] lvl;
        logic          is_full;
        logic          is_empty;
        logic [15:0]   acc;
        logic [7:0]    drp;
    } snap_t;

    int    n_vec = 0;
    int    n_err = 0;
    snap_t s_obs;
    snap_t s_exp;

    // Reference model: a queue of {addr, data} plus two plain counters.
    logic [15:0] mq[$];
    int          m_acc;
    int          m_drp;

    task automatic model_step(input logic w, input logic [7:0] a, input logic [7:0] d,
                              input logic r, input logic rst);
        bit was_full;
        bit popped;
        if (rst) begin
            mq.delete();
            m_acc = 0;
            m_drp = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            popped   = (mq.size() > 0) && r;
            if (popped) void'(mq.pop_front());
            if (w && int'(a) >= LO && int'(a) <= HI) begin
                if (!was_full || popped) begin
                    mq.push_back({a, d});
                    m_acc = (m_acc + 1) % 65536;
                end else if (m_drp < 255) begin
                    m_drp = m_drp + 1;
                end
            end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.valid    = (mq.size() > 0);
        s.addr     = s.valid ? mq[0][15:8] : 8'd0;
        s.data     = s.valid ? mq[0][7:0]  : 8'd0;
        s.lvl      = LW'(mq.size());
        s.is_full  = (mq.size() == DEPTH);
        s.is_empty = (mq.size() == 0);
        s.acc      = 16'(m_acc);
        s.drp      = 8'(m_drp);
        return s;
    endfunction

    function automatic snap_t dut_snap();
        return '{out_valid, out_addr, out_data, level, full, empty, accept_cnt, drop_cnt};
    endfunction

    // Drive one cycle of bus/stream inputs, advance the model, and land on the
    // following falling edge where outputs are stable.
    task automatic cycle(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic r, input logic rst);
        write     = w;
        address   = a;
        writedata = d;
        out_ready = r;
        reset     = rst;
        model_step(w, a, d, r, rst);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'd99, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        snap_t rst_val;
        rst_val = '{1'b0, 8'd0, 8'd0, LW'(0), 1'b0, 1'b1, 16'd0, 8'd0};
        for (int i = 0; i < 2; i++) cycle(1'b1, 8'd5, 8'h77, 1'b0, 1'b1);
        n_vec++;
        if (dut_snap() !== rst_val) begin
            n_err++;
            $display("FAIL reset_held: got %h want %h", dut_snap(), rst_val);
        end
        cycle(1'b0, 8'd99, 8'd0, 1'b0, 1'b0);
        n_vec++;
        if (dut_snap() !== rst_val) begin
            n_err++;
            $display("FAIL reset_released: got %h want %h", dut_snap(), rst_val);
        end
    endtask

    task automatic test_master_pattern();
        do_reset();
        for (int cnt = 0; cnt < 10; cnt++) begin
            cycle(1'b1, 8'(cnt), 8'(cnt), 1'b1, 1'b0);
            n_vec++;
            if ({out_valid, out_addr, out_data} !== {1'b1, 8'(cnt), 8'(cnt)}) begin
                n_err++;
                $display("FAIL master_head[%0d]: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                         cnt, out_valid, out_addr, out_data, cnt, cnt);
            end
            cycle(1'b0, 8'd99, 8'd0, 1'b1, 1'b0);
            n_vec++;
            if (level !== LW'(0)) begin
                n_err++;
                $display("FAIL master_level[%0d]: got %0d want 0", cnt, level);
            end
        end
        n_vec++;
        if ({accept_cnt, drop_cnt} !== {16'd10, 8'd0}) begin
            n_err++;
            $display("FAIL master_counts: got acc=%0d drop=%0d want acc=10 drop=0",
                     accept_cnt, drop_cnt);
        end
    endtask

    task automatic test_window_filter();
        do_reset();
        cycle(1'b1, 8'd98,  8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'd99,  8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'd200, 8'hAA, 1'b0, 1'b0);
        n_vec++;
        if ({out_valid, out_addr, out_data, level, accept_cnt, drop_cnt} !==
            {1'b1, 8'd98, 8'hAA, LW'(1), 16'd1, 8'd0}) begin
            n_err++;
            $display("FAIL window: got v=%b (%0d,%h) lvl=%0d acc=%0d drop=%0d want v=1 (98,aa) lvl=1 acc=1 drop=0",
                     out_valid, out_addr, out_data, level, accept_cnt, drop_cnt);
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(i), 8'(i), 1'b0, 1'b0);
            if (i == 15) begin
                n_vec++;
                if ({full, level} !== {1'b1, LW'(16)}) begin
                    n_err++;
                    $display("FAIL full_after_16: got full=%b lvl=%0d want full=1 lvl=16", full, level);
                end
            end
        end
        n_vec++;
        if ({drop_cnt, level} !== {8'd4, LW'(16)}) begin
            n_err++;
            $display("FAIL drop_after_20: got drop=%0d lvl=%0d want drop=4 lvl=16", drop_cnt, level);
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if ({out_valid, out_addr, out_data} !== {1'b1, 8'(i), 8'(i)}) begin
                n_err++;
                $display("FAIL drain[%0d]: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                         i, out_valid, out_addr, out_data, i, i);
            end
            cycle(1'b0, 8'd99, 8'd0, 1'b1, 1'b0);
        end
        n_vec++;
        if ({empty, out_valid, out_addr, out_data} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_err++;
            $display("FAIL drained_empty: got e=%b v=%b (%0d,%0d) want e=1 v=0 (0,0)",
                     empty, out_valid, out_addr, out_data);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] ea;
        logic [7:0] ed;
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 8'(8'h80 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'd7, 8'h55, 1'b1, 1'b0);
        n_vec++;
        if ({level, full, drop_cnt} !== {LW'(16), 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL full_pop: got lvl=%0d full=%b drop=%0d want lvl=16 full=1 drop=0",
                     level, full, drop_cnt);
        end
        for (int k = 0; k < 16; k++) begin
            ea = (k < 15) ? 8'(k + 1)        : 8'd7;
            ed = (k < 15) ? 8'(8'h81 + k)    : 8'h55;
            n_vec++;
            if ({out_valid, out_addr, out_data} !== {1'b1, ea, ed}) begin
                n_err++;
                $display("FAIL full_pop_drain[%0d]: got v=%b (%0d,%h) want v=1 (%0d,%h)",
                         k, out_valid, out_addr, out_data, ea, ed);
            end
            cycle(1'b0, 8'd99, 8'd0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'd10, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i % 99), 8'(i), 1'b0, 1'b0);
        n_vec++;
        if (drop_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
        end
        s_obs = dut_snap();
        s_exp = model_snap();
        n_vec++;
        if (s_obs !== s_exp) begin
            n_err++;
            $display("FAIL saturate_state: got %h want %h", s_obs, s_exp);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(20 + i), 8'(i), 1'b0, 1'b0);
        n_vec++;
        if (level !== LW'(5)) begin
            n_err++;
            $display("FAIL mid_fill: got lvl=%0d want 5", level);
        end
        cycle(1'b1, 8'd50, 8'd50, 1'b0, 1'b1);
        n_vec++;
        if ({empty, out_valid, level, accept_cnt} !== {1'b1, 1'b0, LW'(0), 16'd0}) begin
            n_err++;
            $display("FAIL mid_reset: got e=%b v=%b lvl=%0d acc=%0d want e=1 v=0 lvl=0 acc=0",
                     empty, out_valid, level, accept_cnt);
        end
        cycle(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        n_vec++;
        if ({out_valid, out_addr, out_data, level} !== {1'b1, 8'd3, 8'd3, LW'(1)}) begin
            n_err++;
            $display("FAIL mid_next_head: got v=%b (%0d,%0d) lvl=%0d want v=1 (3,3) lvl=1",
                     out_valid, out_addr, out_data, level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'(i), ~8'(i), 1'b1, 1'b0);
            n_vec++;
            if ({out_valid, out_addr, out_data, level} !== {1'b1, 8'(i), ~8'(i), LW'(1)}) begin
                n_err++;
                $display("FAIL b2b[%0d]: got v=%b (%0d,%h) lvl=%0d want v=1 (%0d,%h) lvl=1",
                         i, out_valid, out_addr, out_data, level, i, ~8'(i));
            end
        end
        n_vec++;
        if (accept_cnt !== 16'd40) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want 40", accept_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] picks [8];
        picks = '{8'd0, 8'd1, 8'd97, 8'd98, 8'd99, 8'd100, 8'd255, 8'd42};
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : picks[$urandom_range(0, 7)];
            cycle($urandom_range(0, 3) != 0, a, 8'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
            s_obs = dut_snap();
            s_exp = model_snap();
            n_vec++;
            if (s_obs !== s_exp) begin
                n_err++;
                $display("FAIL random[%0d]: got %h want %h", i, s_obs, s_exp);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        write     = 1'b0;
        address   = 8'd99;
        writedata = 8'd0;
        out_ready = 1'b0;
        m_acc     = 0;
        m_drp     = 0;
        @(negedge CLK);
        test_reset();
        test_master_pattern();
        test_window_filter();
        test_full_drop();
        test_full_pop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
